ebpc_enc_arbiter: RTL

//  Shares one ebpc_encoder between NUM_CH input streams at tensor granularity. A channel is granted

---
 rtl/ebpc_pkg.sv | 9 +
 rtl/ebpc_enc_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/ebpc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ebpc_pkg: shared EBPC datapath constants
// Rev 1.0
// ---------------------------------------------------------------------------
package ebpc_pkg;
  localparam int unsigned DATA_W = 8;
endpackage
`default_nettype wire

// File: rtl/ebpc_enc_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ebpc_enc_arbiter: round-robin, tensor-granular sharing of one ebpc_encoder
// Rev 1.0
// ---------------------------------------------------------------------------
module ebpc_enc_arbiter
  import ebpc_pkg::*;
#(
  parameter  int unsigned NUM_CH = 4,
  parameter  int unsigned CNT_W  = 24,
  localparam int unsigned CH_W   = $clog2(NUM_CH)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
  input  logic [NUM_CH-1:0]        ch_last_i,
  input  logic [NUM_CH-1:0]        ch_vld_i,
  output logic [NUM_CH-1:0]        ch_rdy_o,
  output logic [DATA_W-1:0]        enc_data_o,
  output logic                     enc_last_o,
  output logic                     enc_vld_o,
  input  logic                     enc_rdy_i,
  input  logic                     enc_idle_i,
  input  logic                     znz_vld_i,
  input  logic                     znz_rdy_i,
  input  logic                     bpc_vld_i,
  input  logic                     bpc_rdy_i,
  output logic                     busy_o,
  output logic [CH_W-1:0]          grant_o,
  output logic                     done_vld_o,
  input  logic                     done_rdy_i,
  output logic [CH_W-1:0]          done_ch_o,
  output logic [CNT_W-1:0]         done_in_cnt_o,
  output logic [CNT_W-1:0]         done_znz_cnt_o,
  output logic [CNT_W-1:0]         done_bpc_cnt_o
);

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } state_e;

  state_e            state_q;
  logic [CH_W-1:0]   rr_ptr_q;
  logic [CH_W-1:0]   grant_q;
  logic              drain_first_q;
  logic [CNT_W-1:0]  in_cnt_q;
  logic [CNT_W-1:0]  znz_cnt_q;
  logic [CNT_W-1:0]  bpc_cnt_q;

  logic              any_req;
  logic [CH_W-1:0]   winner;
  logic [CH_W:0]     idx;
  logic              in_xfer;
  logic              znz_hs;
  logic              bpc_hs;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  // Search starts at rr_ptr and wraps; the first requester found wins.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    idx     = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = {1'b0, rr_ptr_q} + (CH_W+1)'(i);
      if (idx >= (CH_W+1)'(NUM_CH)) idx = idx - (CH_W+1)'(NUM_CH);
      if (!any_req && ch_vld_i[idx[CH_W-1:0]]) begin
        any_req = 1'b1;
        winner  = idx[CH_W-1:0];
      end
    end
  end

  always_comb begin
    ch_rdy_o   = '0;
    enc_vld_o  = 1'b0;
    enc_last_o = 1'b0;
    enc_data_o = '0;
    if (state_q == STREAM) begin
      ch_rdy_o[grant_q] = enc_rdy_i;
      enc_vld_o         = ch_vld_i[grant_q];
      enc_last_o        = ch_last_i[grant_q];
      enc_data_o        = ch_data_i[DATA_W*grant_q +: DATA_W];
    end
  end

  assign in_xfer = (state_q == STREAM) && ch_vld_i[grant_q] && enc_rdy_i;
  assign znz_hs  = znz_vld_i && znz_rdy_i;
  assign bpc_hs  = bpc_vld_i && bpc_rdy_i;

  assign busy_o         = (state_q != ARB);
  assign grant_o        = grant_q;
  assign done_vld_o     = (state_q == REPORT);
  assign done_ch_o      = grant_q;
  assign done_in_cnt_o  = in_cnt_q;
  assign done_znz_cnt_o = znz_cnt_q;
  assign done_bpc_cnt_o = bpc_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ARB;
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      drain_first_q <= 1'b0;
      in_cnt_q      <= '0;
      znz_cnt_q     <= '0;
      bpc_cnt_q     <= '0;
    end else begin
      case (state_q)
        ARB: begin
          if (any_req) begin
            grant_q   <= winner;
            rr_ptr_q  <= (winner == CH_W'(NUM_CH - 1)) ? '0 : winner + CH_W'(1);
            in_cnt_q  <= '0;
            znz_cnt_q <= '0;
            bpc_cnt_q <= '0;
            state_q   <= STREAM;
          end
        end
        STREAM: begin
          in_cnt_q  <= sat_inc(in_cnt_q, in_xfer);
          znz_cnt_q <= sat_inc(znz_cnt_q, znz_hs);
          bpc_cnt_q <= sat_inc(bpc_cnt_q, bpc_hs);
          if (in_xfer && ch_last_i[grant_q]) begin
            drain_first_q <= 1'b1;
            state_q       <= DRAIN;
          end
        end
        DRAIN: begin
          znz_cnt_q     <= sat_inc(znz_cnt_q, znz_hs);
          bpc_cnt_q     <= sat_inc(bpc_cnt_q, bpc_hs);
          drain_first_q <= 1'b0;
          // The encoder only drops idle a cycle after the last word, so skip the first look.
          if (!drain_first_q && enc_idle_i) state_q <= REPORT;
        end
        REPORT: begin
          if (done_rdy_i) state_q <= ARB;
        end
        default: state_q <= ARB;
      endcase
    end
  end

endmodule
`default_nettype wire
